// File: rtl/esn_lane_seq.sv
// rtl/esn_lane_seq.sv - multi-lane ESN reservoir/readout sequencer (control, address and enables only).
// Optional busy-cycle counter on perf_cycles is built when ESN_SEQ_PERF_CNT_EN is defined.
module esn_lane_seq #(
  parameter int NODE_NUM   = 1000,
  parameter int LANES      = 4,
  parameter int TIME_POINT = 10,
  parameter int PE_LAT     = 14,
  parameter int ADDR_W     = 10,
  parameter int WADDR_W    = 18,
  parameter int STEP_W     = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               u_load,
  output logic [ADDR_W-1:0]  addr_x,
  output logic               x_rd_bank,
  output logic [WADDR_W-1:0] addr_w,
  output logic               acc_en,
  output logic               acc_first,
  output logic               x_wr,
  output logic [ADDR_W-1:0]  x_wr_addr,
  output logic [LANES-1:0]   x_wr_mask,
  output logic [ADDR_W-1:0]  addr_wout,
  output logic               y_acc_en,
  output logic               y_valid,
  input  logic               y_ready,
  output logic [STEP_W-1:0]  step_idx,
  output logic [31:0]        perf_cycles
);

  localparam int G     = (NODE_NUM + LANES - 1) / LANES;
  localparam int G_W   = (G > 1) ? $clog2(G) : 1;
  localparam int LAT_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_U, S_ACC, S_DRAIN, S_XWR, S_RD, S_RDRAIN, S_YOUT, S_DONE
  } state_t;

  state_t               state_q;
  logic [ADDR_W-1:0]    j_q;
  logic [LAT_W-1:0]     lat_q;
  logic [G_W-1:0]       g_q;
  logic [ADDR_W-1:0]    grp_base_q;
  logic                 busy_q, done_q, u_load_q, acc_en_q, acc_first_q;
  logic                 x_wr_q, y_acc_en_q, y_valid_q, bank_q;
  logic [ADDR_W-1:0]    addr_x_q, x_wr_addr_q, addr_wout_q;
  logic [WADDR_W-1:0]   addr_w_q;
  logic [LANES-1:0]     x_wr_mask_q;
  logic [STEP_W-1:0]    step_q;

  // Outputs are registered: each transition loads the values the next state presents.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      j_q         <= '0;
      lat_q       <= '0;
      g_q         <= '0;
      grp_base_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      u_load_q    <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_first_q <= 1'b0;
      x_wr_q      <= 1'b0;
      y_acc_en_q  <= 1'b0;
      y_valid_q   <= 1'b0;
      bank_q      <= 1'b0;
      addr_x_q    <= '0;
      x_wr_addr_q <= '0;
      addr_wout_q <= '0;
      addr_w_q    <= '0;
      x_wr_mask_q <= '0;
      step_q      <= '0;
    end else begin
      done_q      <= 1'b0;
      u_load_q    <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_first_q <= 1'b0;
      x_wr_q      <= 1'b0;
      y_acc_en_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LOAD_U;
            busy_q     <= 1'b1;
            u_load_q   <= 1'b1;
            step_q     <= '0;
            g_q        <= '0;
            grp_base_q <= '0;
          end
        end
        S_LOAD_U: begin
          state_q     <= S_ACC;
          j_q         <= '0;
          addr_x_q    <= '0;
          addr_w_q    <= '0;
          acc_en_q    <= 1'b1;
          acc_first_q <= 1'b1;
        end
        S_ACC: begin
          if (j_q == ADDR_W'(NODE_NUM - 1)) begin
            state_q <= S_DRAIN;
            lat_q   <= '0;
          end else begin
            j_q      <= j_q + ADDR_W'(1);
            addr_x_q <= j_q + ADDR_W'(1);
            addr_w_q <= addr_w_q + WADDR_W'(1);
            acc_en_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (lat_q == LAT_W'(PE_LAT - 1)) begin
            state_q     <= S_XWR;
            x_wr_q      <= 1'b1;
            x_wr_addr_q <= grp_base_q;
            for (int l = 0; l < LANES; l++)
              x_wr_mask_q[l] <= (int'(grp_base_q) + l) < NODE_NUM;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        S_XWR: begin
          j_q      <= '0;
          addr_x_q <= '0;
          if (g_q != G_W'(G - 1)) begin
            state_q     <= S_ACC;
            g_q         <= g_q + G_W'(1);
            grp_base_q  <= grp_base_q + ADDR_W'(LANES);
            addr_w_q    <= addr_w_q + WADDR_W'(1);
            acc_en_q    <= 1'b1;
            acc_first_q <= 1'b1;
          end else begin
            // Readout consumes the bank just written, so flip before the first read.
            state_q     <= S_RD;
            bank_q      <= ~bank_q;
            addr_wout_q <= '0;
            y_acc_en_q  <= 1'b1;
          end
        end
        S_RD: begin
          if (j_q == ADDR_W'(NODE_NUM - 1)) begin
            state_q <= S_RDRAIN;
            lat_q   <= '0;
          end else begin
            j_q         <= j_q + ADDR_W'(1);
            addr_x_q    <= j_q + ADDR_W'(1);
            addr_wout_q <= j_q + ADDR_W'(1);
            y_acc_en_q  <= 1'b1;
          end
        end
        S_RDRAIN: begin
          if (lat_q == LAT_W'(PE_LAT - 1)) begin
            state_q   <= S_YOUT;
            y_valid_q <= 1'b1;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        S_YOUT: begin
          if (y_ready) begin
            y_valid_q <= 1'b0;
            if (step_q == STEP_W'(TIME_POINT - 1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_LOAD_U;
              step_q     <= step_q + STEP_W'(1);
              g_q        <= '0;
              grp_base_q <= '0;
              u_load_q   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          y_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign u_load    = u_load_q;
  assign addr_x    = addr_x_q;
  assign x_rd_bank = bank_q;
  assign addr_w    = addr_w_q;
  assign acc_en    = acc_en_q;
  assign acc_first = acc_first_q;
  assign x_wr      = x_wr_q;
  assign x_wr_addr = x_wr_addr_q;
  assign x_wr_mask = x_wr_mask_q;
  assign addr_wout = addr_wout_q;
  assign y_acc_en  = y_acc_en_q;
  assign y_valid   = y_valid_q;
  assign step_idx  = step_q;

`ifdef ESN_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      perf_q <= '0;
    else if (state_q == S_IDLE && start)
      perf_q <= '0;
    else if (busy_q && perf_q != 32'hFFFF_FFFF)
      perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_esn_lane_seq.sv
// tb/tb_esn_lane_seq.sv - randomized bench for esn_lane_seq against a per-cycle expected trace.
// The trace is expanded from the step/group/row schedule; y_ready stalls and stray starts are random.
module tb_esn_lane_seq;
  localparam int N  = 6;
  localparam int L  = 4;
  localparam int P  = 3;
  localparam int T  = 2;
  localparam int AW = 10;
  localparam int WW = 18;
  localparam int SW = 8;
  localparam int G  = (N + L - 1) / L;

  logic          clk = 1'b0;
  logic          nrst, start, y_ready;
  logic          busy, done, u_load, x_rd_bank, acc_en, acc_first, x_wr, y_acc_en, y_valid;
  logic [AW-1:0] addr_x, x_wr_addr, addr_wout;
  logic [WW-1:0] addr_w;
  logic [L-1:0]  x_wr_mask;
  logic [SW-1:0] step_idx;
  logic [31:0]   perf_cycles;

  int checks = 0;
  int failures = 0;

  esn_lane_seq #(.NODE_NUM(N), .LANES(L), .TIME_POINT(T), .PE_LAT(P),
                 .ADDR_W(AW), .WADDR_W(WW), .STEP_W(SW)) dut (
    .clk(clk), .nrst(nrst), .start(start), .busy(busy), .done(done), .u_load(u_load),
    .addr_x(addr_x), .x_rd_bank(x_rd_bank), .addr_w(addr_w), .acc_en(acc_en),
    .acc_first(acc_first), .x_wr(x_wr), .x_wr_addr(x_wr_addr), .x_wr_mask(x_wr_mask),
    .addr_wout(addr_wout), .y_acc_en(y_acc_en), .y_valid(y_valid), .y_ready(y_ready),
    .step_idx(step_idx), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit busy, done, u_load, acc_en, acc_first, x_wr, y_acc_en, y_valid, bank;
    int step, ax, aw, xa, xm, awo;
    bit yr, st;
  } rec_t;

  rec_t exp_q[$];
  bit   m_bank = 1'b0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic rec_t mk(input int step);
    rec_t r;
    r.busy = 1; r.done = 0; r.u_load = 0; r.acc_en = 0; r.acc_first = 0;
    r.x_wr = 0; r.y_acc_en = 0; r.y_valid = 0; r.bank = m_bank;
    r.step = step; r.ax = 0; r.aw = 0; r.xa = 0; r.xm = 0; r.awo = 0;
    r.yr = 1'($urandom_range(0, 1)); r.st = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Expand one run into the cycle-by-cycle trace; s0/rest < 0 means random stall counts.
  task automatic build_run(input int s0, input int rest);
    rec_t r;
    int k;
    exp_q.delete();
    for (int s = 0; s < T; s++) begin
      r = mk(s); r.u_load = 1; exp_q.push_back(r);
      for (int g = 0; g < G; g++) begin
        for (int j = 0; j < N; j++) begin
          r = mk(s); r.acc_en = 1; r.acc_first = (j == 0); r.ax = j; r.aw = g * N + j;
          exp_q.push_back(r);
        end
        for (int d = 0; d < P; d++) exp_q.push_back(mk(s));
        r = mk(s); r.x_wr = 1; r.xa = g * L;
        for (int l = 0; l < L; l++) if (g * L + l < N) r.xm |= (1 << l);
        exp_q.push_back(r);
      end
      m_bank = ~m_bank;
      for (int j = 0; j < N; j++) begin
        r = mk(s); r.y_acc_en = 1; r.ax = j; r.awo = j; exp_q.push_back(r);
      end
      for (int d = 0; d < P; d++) exp_q.push_back(mk(s));
      k = (s == 0) ? s0 : rest;
      if (k < 0) k = $urandom_range(0, 3);
      for (int d = 0; d < k; d++) begin
        r = mk(s); r.y_valid = 1; r.yr = 0; exp_q.push_back(r);
      end
      r = mk(s); r.y_valid = 1; r.yr = 1; exp_q.push_back(r);
    end
    r = mk(T - 1); r.done = 1; exp_q.push_back(r);
    r = mk(T - 1); r.busy = 0; r.st = 0; exp_q.push_back(r);
  endtask

  task automatic check_rec(input rec_t r);
    check("ctl", {busy, done, u_load, acc_en, acc_first, x_wr, y_acc_en, y_valid, x_rd_bank},
          {r.busy, r.done, r.u_load, r.acc_en, r.acc_first, r.x_wr, r.y_acc_en, r.y_valid, r.bank});
    check("step_idx", step_idx, r.step);
    if (r.acc_en) check("addr_w", addr_w, r.aw);
    if (r.acc_en || r.y_acc_en) check("addr_x", addr_x, r.ax);
    if (r.y_acc_en) check("addr_wout", addr_wout, r.awo);
    if (r.x_wr) begin
      check("x_wr_addr", x_wr_addr, r.xa);
      check("x_wr_mask", x_wr_mask, r.xm);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, u_load, acc_en, acc_first, x_wr, y_acc_en, y_valid, x_rd_bank}, 0);
    check({tag, "_step"}, step_idx, 0);
    check({tag, "_addr"}, {addr_x, addr_w, x_wr_addr, x_wr_mask, addr_wout}, 0);
    check({tag, "_perf"}, perf_cycles, 0);
  endtask

  task automatic do_run(input int s0, input int rest, input bit abort);
    int abort_at = -1;
    int exp_perf = 0;
    build_run(s0, rest);
    foreach (exp_q[i]) if (exp_q[i].busy) exp_perf++;
    if (abort) begin
      foreach (exp_q[i]) if (abort_at < 0 && exp_q[i].step == 1 && exp_q[i].acc_en) abort_at = i;
      abort_at += $urandom_range(0, N - 1);
    end
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1 start = 1'b1;
    y_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_before_start", busy, 0);
    @(posedge clk); #1;
    foreach (exp_q[i]) begin
      start   = exp_q[i].st;
      y_ready = exp_q[i].yr;
      if (i == abort_at) begin
        #1 nrst = 1'b0;
        #1 check_all_zero("async_rst");
        @(posedge clk); @(posedge clk); #1;
        nrst  = 1'b1;
        start = 1'b0;
        m_bank = 1'b0;
        @(negedge clk);
        check_all_zero("after_abort");
        @(negedge clk);
        check("no_done_after_abort", {done, busy}, 0);
        return;
      end
      @(negedge clk);
      check_rec(exp_q[i]);
      @(posedge clk); #1;
    end
    start = 1'b0;
`ifdef ESN_SEQ_PERF_CNT_EN
    check("perf_cycles", perf_cycles, exp_perf);
`else
    check("perf_cycles", perf_cycles, 0);
`endif
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; y_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 nrst = 1'b1;
    do_run(0, 0, 1'b0);
    do_run(5, 0, 1'b0);
    repeat (3) do_run(-1, -1, 1'b0);
    do_run(-1, -1, 1'b1);
    do_run(0, 0, 1'b0);
    do_run(-1, -1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
